// File: rtl/scan_seq_ctrl.sv
// Scan sequencer for a multiplexed LED panel.
// Runs shift -> latch -> binary-weighted display (-> optional blank) -> advance
// over bit planes, then rows, then panels.
// Optional build macro SCAN_BLANK_EN inserts BLANK_CYC dead-time cycles after each
// display period. When it is undefined, DISPLAY goes straight to ADVANCE.
module scan_seq_ctrl #(
   parameter int unsigned PWM_DEPTH = 8,
   parameter int unsigned ROWS      = 8,
   parameter int unsigned PANELS    = 4,
   parameter int unsigned BASE_ON   = 4,
   parameter int unsigned BLANK_CYC = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          enable_i,
   output logic                          shift_req_o,
   input  logic                          shift_done_i,
   output logic [$clog2(ROWS)-1:0]       row_o,
   output logic [$clog2(PANELS)-1:0]     panel_o,
   output logic [$clog2(PWM_DEPTH)-1:0]  plane_o,
   output logic                          led_latch_o,
   output logic                          led_en_o,
   output logic                          frame_end_o,
   output logic                          busy_o
);

   localparam int unsigned PlaneW = $clog2(PWM_DEPTH);
   localparam int unsigned RowW   = $clog2(ROWS);
   localparam int unsigned PanelW = $clog2(PANELS);
   // Longest display period belongs to the top plane.
   localparam int unsigned MaxOn  = BASE_ON << (PWM_DEPTH - 1);
   localparam int unsigned CntW   = $clog2(MaxOn + 1);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StShift   = 3'd1;
   localparam logic [2:0] StLatch   = 3'd2;
   localparam logic [2:0] StDisplay = 3'd3;
   localparam logic [2:0] StBlank   = 3'd4;
   localparam logic [2:0] StAdvance = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [CntW-1:0]   on_cnt_q, on_cnt_d;
   logic [CntW-1:0]   on_len;
   logic [PlaneW-1:0] plane_q, plane_d;
   logic [RowW-1:0]   row_q, row_d;
   logic [PanelW-1:0] panel_q, panel_d;
   logic              last_plane, last_row, last_panel, wrap_all;

`ifdef SCAN_BLANK_EN
   localparam int unsigned BlkW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   logic [BlkW-1:0]   blk_cnt_q, blk_cnt_d;
`endif

   assign last_plane = (plane_q == PlaneW'(PWM_DEPTH - 1));
   assign last_row   = (row_q == RowW'(ROWS - 1));
   assign last_panel = (panel_q == PanelW'(PANELS - 1));
   assign wrap_all   = last_plane && last_row && last_panel;
   assign on_len     = CntW'(BASE_ON) << plane_q;

   // Next-state, counter and index update logic.
   always_comb begin
      state_d  = state_q;
      on_cnt_d = on_cnt_q;
      plane_d  = plane_q;
      row_d    = row_q;
      panel_d  = panel_q;
`ifdef SCAN_BLANK_EN
      blk_cnt_d = blk_cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (enable_i) state_d = StShift;
         end
         StShift: begin
            if (shift_done_i) state_d = StLatch;
         end
         StLatch: begin
            state_d  = StDisplay;
            // Count down to zero so the display lasts exactly on_len cycles.
            on_cnt_d = on_len - CntW'(1);
         end
         StDisplay: begin
            if (on_cnt_q == '0) begin
`ifdef SCAN_BLANK_EN
               state_d   = StBlank;
               blk_cnt_d = BlkW'(BLANK_CYC - 1);
`else
               state_d   = StAdvance;
`endif
            end else begin
               on_cnt_d = on_cnt_q - CntW'(1);
            end
         end
`ifdef SCAN_BLANK_EN
         StBlank: begin
            if (blk_cnt_q == '0) state_d = StAdvance;
            else blk_cnt_d = blk_cnt_q - BlkW'(1);
         end
`endif
         StAdvance: begin
            if (last_plane) begin
               plane_d = '0;
               if (last_row) begin
                  row_d   = '0;
                  panel_d = last_panel ? '0 : panel_q + PanelW'(1);
               end else begin
                  row_d = row_q + RowW'(1);
               end
            end else begin
               plane_d = plane_q + PlaneW'(1);
            end
            // A dropped enable only takes effect once the frame is complete.
            state_d = (wrap_all && !enable_i) ? StIdle : StShift;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         on_cnt_q <= '0;
         plane_q  <= '0;
         row_q    <= '0;
         panel_q  <= '0;
`ifdef SCAN_BLANK_EN
         blk_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         on_cnt_q <= on_cnt_d;
         plane_q  <= plane_d;
         row_q    <= row_d;
         panel_q  <= panel_d;
`ifdef SCAN_BLANK_EN
         blk_cnt_q <= blk_cnt_d;
`endif
      end
   end

   // Moore outputs decoded from the registered state.
   always_comb begin
      shift_req_o = (state_q == StShift);
      led_latch_o = (state_q == StLatch);
      led_en_o    = (state_q == StDisplay);
      busy_o      = (state_q != StIdle);
      frame_end_o = (state_q == StAdvance) && wrap_all;
      row_o       = row_q;
      panel_o     = panel_q;
      plane_o     = plane_q;
   end

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl at default parameters.
module tb_scan_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       done_man = 1'b0;
   logic       auto_en = 1'b0;
   logic       auto_pulse = 1'b0;
   logic       shift_done;
   logic       shift_req_o, led_latch_o, led_en_o, frame_end_o, busy_o;
   logic [2:0] row_o, plane_o;
   logic [1:0] panel_o;

   int checks = 0;
   int errors = 0;
   int latch_cnt = 0;
   int fe_cnt = 0;

   always #5 clk = ~clk;

   assign shift_done = done_man | auto_pulse;

   scan_seq_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .enable_i     (enable),
      .shift_req_o  (shift_req_o),
      .shift_done_i (shift_done),
      .row_o        (row_o),
      .panel_o      (panel_o),
      .plane_o      (plane_o),
      .led_latch_o  (led_latch_o),
      .led_en_o     (led_en_o),
      .frame_end_o  (frame_end_o),
      .busy_o       (busy_o)
   );

   // Shifter model: answers each request after one cycle.
   always @(negedge clk) begin
      if (auto_en && shift_req_o && !auto_pulse) auto_pulse = 1'b1;
      else auto_pulse = 1'b0;
   end

   // Event counters since the last reset.
   always @(negedge clk) begin
      if (rst) begin
         latch_cnt = 0;
         fe_cnt    = 0;
      end else begin
         if (led_latch_o) latch_cnt++;
         if (frame_end_o) fe_cnt++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_latch(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (led_latch_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic disp_len(output int len);
      len = 0;
      @(negedge clk);
      while (led_en_o === 1'b1 && len < 5000) begin
         len++;
         @(negedge clk);
      end
   endtask

   // Expected bits: {shift_req, latch, led_en, busy, frame_end, plane[2:0]}
   typedef struct {
      logic       rst;
      logic       en;
      logic       done;
      logic [7:0] exp;
      string      name;
   } vec_t;

   vec_t tbl[11];

   initial begin
      bit  ok;
      int  len;
      int  gap;
      bit  seen;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'b0000_0000, "reset_state"};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'b1001_0000, "idle_to_shift"};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'b1001_0000, "shift_hold1"};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'b1001_0000, "shift_hold2"};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'b1001_0000, "shift_hold3"};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'b1001_0000, "shift_hold4"};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'b0101_0000, "latch_pulse"};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'b0011_0000, "display_c1"};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'b0011_0000, "stray_done_c2"};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'b0011_0000, "display_c3"};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 8'b0011_0000, "display_c4"};

      for (int i = 0; i < 11; i++) begin
         rst      = tbl[i].rst;
         enable   = tbl[i].en;
         done_man = tbl[i].done;
         @(posedge clk);
         @(negedge clk);
         chk(tbl[i].name, 32'({shift_req_o, led_latch_o, led_en_o, busy_o, frame_end_o,
                               plane_o}), 32'(tbl[i].exp));
      end
      done_man = 1'b0;
      chk("idx_row_panel_basic", 32'({row_o, panel_o}), 32'd0);

      // Binary weighting of planes 1..7 within row 0.
      auto_en = 1'b1;
      for (int p = 1; p < 8; p++) begin
         wait_latch(ok);
         chk("latch_seen", 32'(ok), 32'd1);
         chk("plane_order", 32'(plane_o), 32'(p));
         disp_len(len);
         chk("plane_len", 32'(len), 32'(4 << p));
      end
      wait_latch(ok);
      chk("row_adv_plane", 32'(plane_o), 32'd0);
      chk("row_adv_row", 32'(row_o), 32'd1);
      disp_len(len);
      chk("row1_plane0_len", 32'(len), 32'd4);

      // Drop enable mid-frame; the frame must still complete.
      enable = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40000; i++) begin
         @(negedge clk);
         if (frame_end_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("frame_end_seen", 32'(seen), 32'd1);
      chk("frame_end_idx", 32'({panel_o, row_o, plane_o}), 32'({2'd3, 3'd7, 3'd7}));
      @(negedge clk);
      chk("after_frame_busy", 32'(busy_o), 32'd0);
      chk("after_frame_idx", 32'({panel_o, row_o, plane_o}), 32'd0);
      chk("frame_end_once", 32'(fe_cnt), 32'd1);
      chk("latch_per_frame", 32'(latch_cnt), 32'd256);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (shift_req_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
      end
      chk("stays_idle", 32'(seen), 32'd0);

      // Reset during display of plane 5.
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (led_latch_o === 1'b1 && plane_o == 3'd5) begin
            ok = 1'b1;
            break;
         end
      end
      chk("plane5_reached", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      chk("plane5_displaying", 32'(led_en_o), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midreset_outputs", 32'({shift_req_o, led_latch_o, led_en_o, busy_o, frame_end_o}),
          32'd0);
      chk("midreset_idx", 32'({panel_o, row_o, plane_o}), 32'd0);
      rst = 1'b0;

      // Dead time between end of display and next shift request.
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (led_en_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("restart_display", 32'(ok), 32'd1);
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (led_en_o !== 1'b1) break;
      end
      gap = 0;
      while (shift_req_o !== 1'b1 && gap < 20) begin
         gap++;
         @(negedge clk);
      end
`ifdef SCAN_BLANK_EN
      chk("gap_to_shift", 32'(gap), 32'd3);
`else
      chk("gap_to_shift", 32'(gap), 32'd1);
`endif
      chk("next_plane", 32'(plane_o), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scan_seq_ctrl.md
SCAN_SEQ_CTRL -- requirements
Module: scan_seq_ctrl

Interface
REQ-001 Parameter PWM_DEPTH, default 8: number of binary-coded bit planes per row.
REQ-002 Parameter ROWS, default 8: rows per panel.
REQ-003 Parameter PANELS, default 4: panels scanned in sequence.
REQ-004 Parameter BASE_ON, default 4: display cycles for bit plane 0.
REQ-005 Parameter BLANK_CYC, default 2: dead-time cycles after each display period.
REQ-006 clk_i  input  1  single clock; all logic on its rising edge.
REQ-007 rst_i  input  1  reset; synchronous and active-high.
REQ-008 enable_i  input  1  scan run request.
REQ-009 shift_req_o  output  1  asks the column shifter to shift the current row/plane.
REQ-010 shift_done_i  input  1  one-cycle pulse from the shifter when the shift is complete.
REQ-011 row_o  output  $clog2(ROWS)  current row index.
REQ-012 panel_o  output  $clog2(PANELS)  current panel index.
REQ-013 plane_o  output  $clog2(PWM_DEPTH)  current bit plane.
REQ-014 led_latch_o  output  1  one-cycle latch strobe.
REQ-015 led_en_o  output  1  display enable, active-high.
REQ-016 frame_end_o  output  1  one-cycle pulse at the end of each frame.
REQ-017 busy_o  output  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, SHIFT, LATCH, DISPLAY, BLANK, ADVANCE.
REQ-019 IDLE: when enable_i=1, go to SHIFT on the next cycle; otherwise stay in IDLE.
REQ-020 SHIFT: hold shift_req_o=1; on shift_done_i=1, drop shift_req_o the next cycle and go to LATCH.
REQ-021 shift_done_i is ignored in every state except SHIFT.
REQ-022 LATCH: led_latch_o=1 for exactly one cycle, then go to DISPLAY.
REQ-023 DISPLAY: led_en_o=1 for exactly BASE_ON<<plane_o cycles, then go to BLANK or ADVANCE per REQ-033/034.
REQ-024 Display counter width is sufficient for BASE_ON<<(PWM_DEPTH-1) with no overflow.
REQ-025 led_en_o is 0 in every state except DISPLAY; led_latch_o and led_en_o are never high in the same cycle.
REQ-026 row_o, panel_o and plane_o stay constant from SHIFT entry through the end of BLANK.
REQ-027 row_o, panel_o and plane_o change only in ADVANCE.
REQ-028 Scan order: plane innermost, 0 up to PWM_DEPTH-1; then row 0 up to ROWS-1; then panel 0 up to PANELS-1. Each index wraps to 0.
REQ-029 frame_end_o pulses for one cycle in the ADVANCE that wraps panel, row and plane together.
REQ-030 ADVANCE lasts one cycle. Next state is SHIFT, except at frame end with enable_i=0, where the next state is IDLE.
REQ-031 enable_i deasserted mid-frame: the current frame completes, then the block enters IDLE.
REQ-032 Reference period, PWM_DEPTH=8, BASE_ON=4, no blanking: one row spans 1020 display cycles.

Configuration
REQ-033 Macro SCAN_BLANK_EN defined: after DISPLAY, enter BLANK with led_en_o=0 for BLANK_CYC cycles, then go to ADVANCE.
REQ-034 Macro SCAN_BLANK_EN undefined: BLANK and its counter are not built; DISPLAY goes directly to ADVANCE.

Reset
REQ-035 rst_i=1 at a clock edge forces state IDLE from any state, including mid-DISPLAY or mid-SHIFT.
REQ-036 Reset clears all counters and drives row_o=0, panel_o=0, plane_o=0.
REQ-037 Reset drives shift_req_o, led_latch_o, led_en_o, frame_end_o and busy_o to 0 on the following cycle.

Verification
REQ-038 Basic sequence: reset, enable_i=1, shift_done_i 5 cycles after shift_req_o rises -> shift_req_o falls 1 cycle later, one latch pulse, led_en_o high 4 cycles for plane 0.
REQ-039 Plane weighting: record the DISPLAY length for plane 7 -> exactly 512 cycles; the plane sequence observed is 0,1,...,7, then row_o increments.
REQ-040 Full frame: auto-responding shifter -> frame_end_o pulses once after 4x8x8=256 latch pulses; row_o, panel_o and plane_o all return to 0.
REQ-041 Enable drop: enable_i=0 mid-frame -> scan continues to frame_end_o, then busy_o=0 with no further shift_req_o.
REQ-042 Stray handshake: shift_done_i pulsed during DISPLAY -> ignored, with no extra latch pulse.
REQ-043 Mid-operation reset: rst_i asserted during DISPLAY of plane 5 -> the next cycle has led_en_o=0 and all indices 0; with SCAN_BLANK_EN defined, 2 blank cycles separate DISPLAY from the next shift_req_o.
